// File: rtl/inst_buffer_if.sv
// Fetch/decode signal bundle of the instruction buffer.
// master = pipeline side (fetch, stall control, decode), slave = inst_buffer.
`ifndef StallBus
`define StallBus 6
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif

interface inst_buffer_if;
    logic [`StallBus-1:0]    stall;
    logic                    flush;
    logic [31:0]             new_pc;
    logic [`IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [63:0]             inst_sram_rdata;
    logic [1:0]              issue_cnt;
    logic                    inst0_valid;
    logic [31:0]             inst0_pc;
    logic [31:0]             inst0;
    logic                    inst1_valid;
    logic [31:0]             inst1_pc;
    logic [31:0]             inst1;
    logic                    stallreq_for_buf;
    logic                    empty;

    modport master (
        output stall, flush, new_pc, if_to_id_bus, inst_sram_rdata, issue_cnt,
        input  inst0_valid, inst0_pc, inst0, inst1_valid, inst1_pc, inst1,
               stallreq_for_buf, empty
    );

    modport slave (
        input  stall, flush, new_pc, if_to_id_bus, inst_sram_rdata, issue_cnt,
        output inst0_valid, inst0_pc, inst0, inst1_valid, inst1_pc, inst1,
               stallreq_for_buf, empty
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and dual-issue decode.
// Optional feature: define INST_BUF_BYPASS_EN to forward arrivals into an empty queue straight to decode.
`ifndef StallBus
`define StallBus 6
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif

module inst_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    inst_buffer_if.slave bus
);
    // Leaves room for the two pairs that may still be in flight once fetch sees the request.
    localparam logic [ADDR_W:0] STALL_THR = (ADDR_W + 1)'(DEPTH - 6);

    logic              r_d_ce;
    logic [31:0]       r_d_pc;
    logic              r_drop_first;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_mem_inst [DEPTH];
    logic [31:0]       r_mem_pc   [DEPTH];

    logic              w_stop;
    logic              w_arrive;
    logic              w_bypass;
    logic [31:0]       w_arr_inst [2];
    logic [31:0]       w_arr_pc   [2];
    logic [1:0]        w_nav;
    logic [1:0]        w_ncons;
    logic [1:0]        w_nwr;
    logic [1:0]        w_nrd;
    logic [ADDR_W-1:0] w_rd_ptr1;
    logic [ADDR_W-1:0] w_wr_ptr1;
    logic              w_unused;

    assign w_stop    = (bus.stall[1] == `Stop);
    assign w_arrive  = r_d_ce & ~bus.flush & ~rst;
    assign w_rd_ptr1 = r_rd_ptr + ADDR_W'(1);
    assign w_wr_ptr1 = r_wr_ptr + ADDR_W'(1);
    assign w_unused  = ^{bus.stall[`StallBus-1:2], bus.stall[0], bus.new_pc[31:3], bus.new_pc[1:0]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_arr_inst[0] = bus.inst_sram_rdata[31:0];
        w_arr_pc[0]   = r_d_pc;
        w_arr_inst[1] = bus.inst_sram_rdata[63:32];
        w_arr_pc[1]   = r_d_pc + 32'd4;
        w_nav         = 2'd0;
        // A misaligned branch target skips the low word of the first pair.
        if (r_drop_first) begin
            w_arr_inst[0] = bus.inst_sram_rdata[63:32];
            w_arr_pc[0]   = r_d_pc + 32'd4;
        end
        if (w_arrive) begin
            w_nav = r_drop_first ? 2'd1 : 2'd2;
        end
    end

`ifdef INST_BUF_BYPASS_EN
    assign w_bypass = (r_count == '0) & w_arrive & ~w_stop;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_nrd   = 2'd0;
        w_ncons = 2'd0;
        if (!w_stop) begin
            if (r_count >= (ADDR_W + 1)'(bus.issue_cnt)) begin
                w_nrd = bus.issue_cnt;
            end else begin
                w_nrd = r_count[1:0];
            end
            if (w_bypass) begin
                w_ncons = (bus.issue_cnt >= w_nav) ? w_nav : bus.issue_cnt;
            end
        end
        // Words decode takes straight from the bypass never occupy an entry.
        w_nwr = w_nav - w_ncons;
    end

    always_comb begin
        bus.inst0_valid = (r_count >= (ADDR_W + 1)'(1));
        bus.inst0_pc    = r_mem_pc[r_rd_ptr];
        bus.inst0       = r_mem_inst[r_rd_ptr];
        bus.inst1_valid = (r_count >= (ADDR_W + 1)'(2));
        bus.inst1_pc    = r_mem_pc[w_rd_ptr1];
        bus.inst1       = r_mem_inst[w_rd_ptr1];
        if (w_bypass) begin
            bus.inst0_valid = (w_nav >= 2'd1);
            bus.inst0_pc    = w_arr_pc[0];
            bus.inst0       = w_arr_inst[0];
            bus.inst1_valid = (w_nav >= 2'd2);
            bus.inst1_pc    = w_arr_pc[1];
            bus.inst1       = w_arr_inst[1];
        end
    end

    assign bus.empty            = (r_count == '0);
    assign bus.stallreq_for_buf = (r_count > STALL_THR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_ce       <= 1'b0;
            r_d_pc       <= '0;
            r_drop_first <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else if (bus.flush) begin
            r_d_ce       <= 1'b0;
            r_d_pc       <= '0;
            r_drop_first <= bus.new_pc[2];
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_d_ce   <= bus.if_to_id_bus[`IF_TO_ID_WD-1];
            r_d_pc   <= bus.if_to_id_bus[31:0];
            r_rd_ptr <= r_rd_ptr + ADDR_W'(w_nrd);
            r_wr_ptr <= r_wr_ptr + ADDR_W'(w_nwr);
            r_count  <= r_count + (ADDR_W + 1)'(w_nwr) - (ADDR_W + 1)'(w_nrd);
            if (w_arrive) begin
                r_drop_first <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; count gates validity, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (w_nwr != 2'd0) begin
            r_mem_inst[r_wr_ptr] <= w_arr_inst[w_ncons[0]];
            r_mem_pc[r_wr_ptr]   <= w_arr_pc[w_ncons[0]];
        end
        if (w_nwr == 2'd2) begin
            r_mem_inst[w_wr_ptr1] <= w_arr_inst[1];
            r_mem_pc[w_wr_ptr1]   <= w_arr_pc[1];
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed vector table, then queue-model-checked sequences.
module tb_inst_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_buffer_if bus ();

    inst_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic drive(input logic r, input logic ce, input logic [31:0] pc, input logic [63:0] rdata,
                         input logic [1:0] issue, input logic stop, input logic fl, input logic [31:0] npc);
        rst                 = r;
        bus.if_to_id_bus    = {ce, pc};
        bus.inst_sram_rdata = rdata;
        bus.issue_cnt       = issue;
        bus.stall           = stop ? 6'b000010 : 6'b000000;
        bus.flush           = fl;
        bus.new_pc          = npc;
    endtask

    typedef struct {
        logic        r;
        logic        ce;
        logic [31:0] pc;
        logic [63:0] rdata;
        logic [1:0]  issue;
        logic        stop;
        logic        fl;
        logic [31:0] npc;
        logic        v0;
        logic [31:0] pc0;
        logic [31:0] i0;
        logic        v1;
        logic [31:0] pc1;
        logic [31:0] i1;
        logic        sreq;
        logic        emp;
    } vec_t;

    // Queue model: entries hold PCs; the instruction at a PC is mem_word(pc).
    logic [31:0] mq[$];
    logic        m_dce;
    logic [31:0] m_dpc;
    logic        m_drop;
    logic [31:0] prev_pc;
    bit          track;
    logic [31:0] popped[$];

    task automatic cyc(input logic r, input logic ce, input logic [31:0] pc, input logic [1:0] issue,
                       input logic stop, input logic fl, input logic [31:0] npc);
        logic [31:0] arr[$];
        logic [31:0] view[$];
        bit          byp;
        int          n;
        drive(r, ce, pc, {mem_word(prev_pc + 32'd4), mem_word(prev_pc)}, issue, stop, fl, npc);
        prev_pc = pc;
        if (m_dce && !fl && !r) begin
            if (!m_drop) arr.push_back(m_dpc);
            arr.push_back(m_dpc + 32'd4);
        end
        byp = 1'b0;
`ifdef INST_BUF_BYPASS_EN
        byp = (mq.size() == 0) && (arr.size() != 0) && !stop;
`endif
        if (byp) view = arr;
        else     view = mq;
        n = stop ? 0 : ((int'(issue) < view.size()) ? int'(issue) : view.size());

        @(negedge clk);
        check("inst0_valid", bus.inst0_valid, view.size() >= 1);
        if (view.size() >= 1) begin
            check("inst0_pc", bus.inst0_pc, view[0]);
            check("inst0", bus.inst0, mem_word(view[0]));
        end
        check("inst1_valid", bus.inst1_valid, view.size() >= 2);
        if (view.size() >= 2) begin
            check("inst1_pc", bus.inst1_pc, view[1]);
            check("inst1", bus.inst1, mem_word(view[1]));
        end
        check("stallreq", bus.stallreq_for_buf, mq.size() > 10);
        check("empty", bus.empty, mq.size() == 0);
        if (track) begin
            for (int k = 0; k < n; k++) popped.push_back((k == 0) ? bus.inst0_pc : bus.inst1_pc);
        end

        @(posedge clk);
        if (r) begin
            mq.delete();
            m_dce = 1'b0; m_dpc = '0; m_drop = 1'b0;
        end else if (fl) begin
            mq.delete();
            m_dce = 1'b0; m_dpc = '0; m_drop = npc[2];
        end else begin
            if (byp) repeat (n) void'(arr.pop_front());
            else     repeat (n) void'(mq.pop_front());
            foreach (arr[k]) mq.push_back(arr[k]);
            if (m_dce) m_drop = 1'b0;
            m_dce = ce; m_dpc = pc;
        end
        if (mq.size() > 16) check("no_overflow", mq.size(), 16);
        #1;
    endtask

    vec_t        vt[12];
    logic [31:0] wpc;
    logic [31:0] rpc;
    int          issued;

    initial begin
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[1]  = '{0, 1, 32'hbfc00000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[2]  = '{0, 0, 0, {32'h24020002, 32'h24010001}, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[3]  = '{0, 0, 0, 0, 2, 1, 0, 0,  1, 32'hbfc00000, 32'h24010001, 1, 32'hbfc00004, 32'h24020002, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 32'hbfc00000, 32'h24010001, 1, 32'hbfc00004, 32'h24020002, 0, 0};
        vt[5]  = '{0, 1, 32'hbfc00008, 0, 0, 0, 0, 0,  1, 32'hbfc00004, 32'h24020002, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 0, {32'haaaaaaaa, 32'hbbbbbbbb}, 0, 0, 1, 32'hbfc00384,
                   1, 32'hbfc00004, 32'h24020002, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 1, 32'hbfc00380, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{0, 0, 0, {32'h11112222, 32'h33334444}, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        vt[9]  = '{0, 0, 0, 0, 2, 1, 0, 0,  1, 32'hbfc00384, 32'h11112222, 0, 0, 0, 0, 0};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 32'hbfc00384, 32'h11112222, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};

        drive(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].r, vt[i].ce, vt[i].pc, vt[i].rdata, vt[i].issue, vt[i].stop, vt[i].fl, vt[i].npc);
            @(negedge clk);
            check($sformatf("vec%0d_v0", i), bus.inst0_valid, vt[i].v0);
            if (vt[i].v0) begin
                check($sformatf("vec%0d_pc0", i), bus.inst0_pc, vt[i].pc0);
                check($sformatf("vec%0d_i0", i), bus.inst0, vt[i].i0);
            end
            check($sformatf("vec%0d_v1", i), bus.inst1_valid, vt[i].v1);
            if (vt[i].v1) begin
                check($sformatf("vec%0d_pc1", i), bus.inst1_pc, vt[i].pc1);
                check($sformatf("vec%0d_i1", i), bus.inst1, vt[i].i1);
            end
            check($sformatf("vec%0d_sreq", i), bus.stallreq_for_buf, vt[i].sreq);
            check($sformatf("vec%0d_empty", i), bus.empty, vt[i].emp);
            @(posedge clk);
            #1;
        end

        // Model-checked phase starts from reset.
        mq.delete(); m_dce = 1'b0; m_dpc = '0; m_drop = 1'b0; prev_pc = '0; track = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Fill with issue_cnt=0 while fetch honours stallreq, then drain two at a time.
        wpc = 32'h0000_2000;
        for (int c = 0; c < 20; c++) begin
            if (mq.size() <= 10) begin
                cyc(0, 1, wpc, 0, 0, 0, 0);
                wpc += 32'd8;
            end else begin
                cyc(0, 0, 0, 0, 0, 0, 0);
            end
        end
        for (int c = 0; c < 20 && (mq.size() != 0 || m_dce); c++) cyc(0, 0, 0, 2, 0, 0, 0);

        // Stop with four entries and issue_cnt=2: contents and head held.
        cyc(0, 1, 32'h0000_3000, 0, 1, 0, 0);
        cyc(0, 1, 32'h0000_3008, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int c = 0; c < 3; c++) cyc(0, 0, 0, 2, 1, 0, 0);
        check("stop_count_held", mq.size(), 4);
        for (int c = 0; c < 10 && mq.size() != 0; c++) cyc(0, 0, 0, 2, 0, 0, 0);

        // Wrap-around: 40 pairs, issue alternating 1 and 2, PCs must come out consecutively.
        track = 1; popped.delete(); issued = 0; wpc = 32'h0004_0000;
        for (int c = 0; c < 400 && (issued < 40 || mq.size() != 0 || m_dce); c++) begin
            if (issued < 40 && mq.size() <= 10) begin
                cyc(0, 1, wpc, (c % 2 == 1) ? 2'd2 : 2'd1, 0, 0, 0);
                wpc += 32'd8;
                issued++;
            end else begin
                cyc(0, 0, 0, (c % 2 == 1) ? 2'd2 : 2'd1, 0, 0, 0);
            end
        end
        track = 0;
        check("wrap_count", popped.size(), 80);
        for (int i = 0; i < popped.size() && i < 80; i++)
            check($sformatf("wrap_pc%0d", i), popped[i], 32'h0004_0000 + 32'(4 * i));

        // Arrival into an empty buffer with issue_cnt=2.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0000_1000, 0, 0, 0, 0);
        cyc(0, 0, 0, 2, 0, 0, 0);
`ifdef INST_BUF_BYPASS_EN
        check("bypass_count_zero", bus.empty, 1'b1);
`else
        check("nobypass_count_two", bus.inst1_valid, 1'b1);
`endif
        cyc(0, 0, 0, 2, 0, 0, 0);

        // Random traffic with flushes, stalls and occasional resets.
        for (int c = 0; c < 600; c++) begin
            logic r, fl, stp, ce;
            logic [31:0] npc;
            r   = ($urandom_range(99) == 0);
            fl  = ($urandom_range(24) == 0);
            stp = ($urandom_range(3) == 0);
            npc = $urandom();
            rpc = $urandom() & 32'hFFFF_FFF8;
            ce  = ($urandom_range(3) != 0) && (mq.size() <= 10);
            cyc(r, ce, rpc, 2'($urandom_range(2)), stp, fl, npc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
